fc_wr_burst_ctrl: RTL and testbench
===================================

Name: fc_wr_burst_ctrl

Overview:
Parametrised write-back controller for fully-connected layer results. It captures a BATCH_SIZE x BIAS_SIZE result array and splits it into bus write bursts of up to BURST_LEN beats. Each burst runs address, data and response phases with full valid/ready handshakes, and the block reports completion to fc_ctrl. It sits between fully_connect, fc_ctrl and the system bus, and supersedes the single-burst writer.

Parameters:
BATCH_SIZE, 1, batch dimension of the result array
BIAS_SIZE, 10, outputs per batch entry
WORD_LEN, 32, bits per result word and bus data width; multiple of 8
BURST_LEN, 16, maximum beats per burst; range 1..16
ADDR_W, 28, bus address width
AWID, 4'b0110, write ID driven on awuser_id

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
FcNwc_result_en  in  1  result-valid strobe
FcNwc_result  in  BATCH_SIZE*BIAS_SIZE*WORD_LEN  result array; element [b][i] at word index b*BIAS_SIZE+i
NwcFc_busy  out  1  high while a write-back is in progress
NcNwc_initAddr  in  ADDR_W  base byte address
NcNwc_initAddrEn  in  1  base address load strobe
NwcNc_done  out  1  one-cycle completion pulse
NwcBus_awvalid/awaddr/awlen/awuser_id/awuser_ap  out  1/ADDR_W/4/4/1  address channel
BusNwc_awready  in  1  address accept
NwcBus_wvalid/wdata/wstrb/wlast  out  1/WORD_LEN/WORD_LEN/8/1  data channel
BusNwc_wready  in  1  data accept
BusNwc_bvalid  in  1  write response valid
BusNwc_bresp  in  2  response code; nonzero means error
NwcBus_bready  out  1  response accept
NwcNc_err  out  1  sticky error flag; cleared at the next job start

Behaviour:
- Reset: synchronous on rst_n=0. FSM goes to IDLE; all valids, bready, done, busy and err are 0; awaddr, awlen, wdata and wlast are 0; wstrb is all ones; base address is 0.
- Reset takes effect mid-burst. The in-flight job is abandoned and no done pulse is issued.
- Base address loads on NcNwc_initAddrEn in any state. A job latches the base address at its start, so a load mid-job affects only the next job.
- N = BATCH_SIZE*BIAS_SIZE. NB = ceil(N/BURST_LEN) bursts. The last burst has N-(NB-1)*BURST_LEN beats.
- Burst k: awaddr = base + k*BURST_LEN*(WORD_LEN/8), truncated to ADDR_W (wraps). awlen = beats-1. awuser_ap=1, awuser_id=AWID.
- FSM states and transitions:
  - IDLE: on FcNwc_result_en, capture the array and go to AW next cycle; busy rises with the state change.
  - AW: awvalid is held, with awaddr/awlen stable, until awready. The cycle after the handshake goes to W.
  - W: wvalid=1. wdata = word[k*BURST_LEN+beat]. The beat advances only on a wvalid&wready cycle. wlast=1 on the final beat of the burst. After the final handshake, go to B.
  - B: bready=1. On bvalid, set err if bresp!=0. Then go to AW for the next burst, or to DONE after the last burst.
  - DONE: pulse NwcNc_done for 1 cycle, deassert busy, return to IDLE.
- While wvalid=1 and wready=0, wdata and wlast hold unchanged. Same rule for AW while awready=0.
- FcNwc_result_en while busy is ignored; captured data is unchanged. Simultaneous result_en in the DONE cycle is also ignored.
- Minimum latency with ready always high: 1 (AW) + beats (W) + 1 (B) cycles per burst, plus 1 DONE cycle.
- An error does not abort the job; all bursts are still issued.

Decomposition:
- Package fc_wr_pkg holds:
  - the state enum (IDLE, AW, W, B, DONE)
  - the default AWID
  - the bresp OKAY constant
  - a localparam function computing NB
- One natural sub-module, fc_wr_word_sel: a combinational word-index to wdata mux over the captured array. All sequential logic stays in the top module.

Test Plan:
- BATCH 1, BIAS 10, BURST 16, base 0x100, all readys high -> one AW (awaddr 0x100, awlen 9); 10 beats of words 0..9 with wlast on beat 9; done 13 cycles after capture.
- BATCH 2, BIAS 20, base 0x0 -> 3 bursts: awaddr 0x0, 0x40, 0x80; awlen 15, 15, 7; 40 words in index order.
- wready toggled 1010... mid-burst -> wdata/wlast stable during stalls; no beat skipped or duplicated; 10 handshakes total.
- awready held low for 5 cycles -> awvalid held, awaddr unchanged; data phase starts only after accept.
- Second FcNwc_result_en with new data during W -> ignored; original words written; bresp=2'b10 on burst 0 -> err=1 with done still pulsed.
- rst_n low for 1 cycle mid-W -> all outputs at reset values next cycle; no done; a new job then completes normally.

Source files
------------

// File: rtl/fc_wr_pkg.sv
// Shared types and constants for the fully-connected result write-back controller.
package fc_wr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } wr_state_e;

    localparam logic [3:0] AWID_DEFAULT = 4'b0110;
    localparam logic [1:0] BRESP_OKAY   = 2'b00;

    // Number of bursts needed to move n_words at up to burst_len beats each.
    function automatic int calc_nb(input int n_words, input int burst_len);
        return (n_words + burst_len - 1) / burst_len;
    endfunction

endpackage

// File: rtl/fc_wr_word_sel.sv
// Combinational word-index to write-data mux over the captured result array.
module fc_wr_word_sel
    import fc_wr_pkg::*;
#(
    parameter int N_WORDS  = 10,
    parameter int WORD_LEN = 32,
    parameter int IDX_W    = 4
) (
    input  logic [N_WORDS*WORD_LEN-1:0] words,
    input  logic [IDX_W-1:0]            idx,
    output logic [WORD_LEN-1:0]         word
);

    // Out-of-range indices read as zero so the mux never indexes past the array.
    always_comb begin
        word = '0;
        if (int'(idx) < N_WORDS) begin
            word = words[int'(idx)*WORD_LEN +: WORD_LEN];
        end else begin
            word = '0;
        end
    end

endmodule

// File: rtl/fc_wr_burst_ctrl.sv
// Writes a captured BATCH_SIZE x BIAS_SIZE result array to the bus as a sequence
// of AW/W/B bursts of up to BURST_LEN beats, then pulses done.
module fc_wr_burst_ctrl
    import fc_wr_pkg::*;
#(
    parameter int         BATCH_SIZE = 1,
    parameter int         BIAS_SIZE  = 10,
    parameter int         WORD_LEN   = 32,
    parameter int         BURST_LEN  = 16,
    parameter int         ADDR_W     = 28,
    parameter logic [3:0] AWID       = AWID_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  FcNwc_result_en,
    input  logic [BATCH_SIZE*BIAS_SIZE*WORD_LEN-1:0] FcNwc_result,
    output logic                                  NwcFc_busy,
    input  logic [ADDR_W-1:0]                     NcNwc_initAddr,
    input  logic                                  NcNwc_initAddrEn,
    output logic                                  NwcNc_done,
    output logic                                  NwcBus_awvalid,
    output logic [ADDR_W-1:0]                     NwcBus_awaddr,
    output logic [3:0]                            NwcBus_awlen,
    output logic [3:0]                            NwcBus_awuser_id,
    output logic                                  NwcBus_awuser_ap,
    input  logic                                  BusNwc_awready,
    output logic                                  NwcBus_wvalid,
    output logic [WORD_LEN-1:0]                   NwcBus_wdata,
    output logic [WORD_LEN/8-1:0]                 NwcBus_wstrb,
    output logic                                  NwcBus_wlast,
    input  logic                                  BusNwc_wready,
    input  logic                                  BusNwc_bvalid,
    input  logic [1:0]                            BusNwc_bresp,
    output logic                                  NwcBus_bready,
    output logic                                  NwcNc_err
);

    localparam int N_WORDS    = BATCH_SIZE * BIAS_SIZE;
    localparam int NB         = calc_nb(N_WORDS, BURST_LEN);
    localparam int LAST_BEATS = N_WORDS - (NB - 1) * BURST_LEN;
    localparam int IDX_W      = $clog2(N_WORDS + 1);
    localparam int BCNT_W     = $clog2(NB + 1);
    localparam int STRB_W     = WORD_LEN / 8;

    localparam logic [3:0]        FULL_LEN   = 4'(BURST_LEN - 1);
    localparam logic [3:0]        LAST_LEN   = 4'(LAST_BEATS - 1);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(BURST_LEN * STRB_W);
    localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(NB - 1);

    wr_state_e                    state_r, state_nxt_s;
    logic [BCNT_W-1:0]            burst_r, burst_nxt_s;
    logic [3:0]                   beat_r, beat_nxt_s;
    logic [IDX_W-1:0]             word_idx_r, word_idx_nxt_s;
    logic [ADDR_W-1:0]            base_r;
    logic [N_WORDS*WORD_LEN-1:0]  data_r;
    logic                         capture_s;
    logic [IDX_W-1:0]             sel_idx_s;
    logic [WORD_LEN-1:0]          sel_word_s;

    logic                         awvalid_r, awvalid_nxt_s;
    logic [ADDR_W-1:0]            awaddr_r, awaddr_nxt_s;
    logic [3:0]                   awlen_r, awlen_nxt_s;
    logic                         wvalid_r, wvalid_nxt_s;
    logic [WORD_LEN-1:0]          wdata_r, wdata_nxt_s;
    logic                         wlast_r, wlast_nxt_s;
    logic                         bready_r, bready_nxt_s;
    logic                         done_r, done_nxt_s;
    logic                         busy_r, busy_nxt_s;
    logic                         err_r, err_nxt_s;

    // In W the register loads the word after the one currently on the bus.
    always_comb begin
        sel_idx_s = word_idx_r;
        if (state_r == ST_W) begin
            sel_idx_s = word_idx_r + IDX_W'(1);
        end else begin
            sel_idx_s = word_idx_r;
        end
    end

    fc_wr_word_sel #(
        .N_WORDS  (N_WORDS),
        .WORD_LEN (WORD_LEN),
        .IDX_W    (IDX_W)
    ) u_word_sel (
        .words (data_r),
        .idx   (sel_idx_s),
        .word  (sel_word_s)
    );

    // Next-state and next-output logic; every output is then registered.
    always_comb begin
        state_nxt_s    = state_r;
        burst_nxt_s    = burst_r;
        beat_nxt_s     = beat_r;
        word_idx_nxt_s = word_idx_r;
        capture_s      = 1'b0;
        awvalid_nxt_s  = awvalid_r;
        awaddr_nxt_s   = awaddr_r;
        awlen_nxt_s    = awlen_r;
        wvalid_nxt_s   = wvalid_r;
        wdata_nxt_s    = wdata_r;
        wlast_nxt_s    = wlast_r;
        bready_nxt_s   = bready_r;
        done_nxt_s     = 1'b0;
        busy_nxt_s     = busy_r;
        err_nxt_s      = err_r;
        case (state_r)
            ST_IDLE: begin
                if (FcNwc_result_en) begin
                    capture_s      = 1'b1;
                    state_nxt_s    = ST_AW;
                    busy_nxt_s     = 1'b1;
                    err_nxt_s      = 1'b0;
                    awvalid_nxt_s  = 1'b1;
                    awaddr_nxt_s   = base_r;
                    awlen_nxt_s    = (NB == 1) ? LAST_LEN : FULL_LEN;
                    burst_nxt_s    = '0;
                    word_idx_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_AW: begin
                if (BusNwc_awready) begin
                    awvalid_nxt_s = 1'b0;
                    state_nxt_s   = ST_W;
                    wvalid_nxt_s  = 1'b1;
                    wdata_nxt_s   = sel_word_s;
                    wlast_nxt_s   = (awlen_r == 4'd0);
                    beat_nxt_s    = 4'd0;
                end else begin
                    state_nxt_s = ST_AW;
                end
            end
            ST_W: begin
                if (BusNwc_wready) begin
                    word_idx_nxt_s = word_idx_r + IDX_W'(1);
                    if (wlast_r) begin
                        wvalid_nxt_s = 1'b0;
                        wlast_nxt_s  = 1'b0;
                        bready_nxt_s = 1'b1;
                        state_nxt_s  = ST_B;
                    end else begin
                        beat_nxt_s  = beat_r + 4'd1;
                        wdata_nxt_s = sel_word_s;
                        wlast_nxt_s = ((beat_r + 4'd1) == awlen_r);
                    end
                end else begin
                    state_nxt_s = ST_W;
                end
            end
            ST_B: begin
                if (BusNwc_bvalid) begin
                    bready_nxt_s = 1'b0;
                    if (BusNwc_bresp != BRESP_OKAY) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = err_r;
                    end
                    if (burst_r == LAST_BURST) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                        busy_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s   = ST_AW;
                        burst_nxt_s   = burst_r + BCNT_W'(1);
                        awvalid_nxt_s = 1'b1;
                        awaddr_nxt_s  = awaddr_r + STRIDE;
                        awlen_nxt_s   = ((burst_r + BCNT_W'(1)) == LAST_BURST) ? LAST_LEN : FULL_LEN;
                    end
                end else begin
                    state_nxt_s = ST_B;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, counters and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            burst_r    <= '0;
            beat_r     <= 4'd0;
            word_idx_r <= '0;
            awvalid_r  <= 1'b0;
            awaddr_r   <= '0;
            awlen_r    <= 4'd0;
            wvalid_r   <= 1'b0;
            wdata_r    <= '0;
            wlast_r    <= 1'b0;
            bready_r   <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            burst_r    <= burst_nxt_s;
            beat_r     <= beat_nxt_s;
            word_idx_r <= word_idx_nxt_s;
            awvalid_r  <= awvalid_nxt_s;
            awaddr_r   <= awaddr_nxt_s;
            awlen_r    <= awlen_nxt_s;
            wvalid_r   <= wvalid_nxt_s;
            wdata_r    <= wdata_nxt_s;
            wlast_r    <= wlast_nxt_s;
            bready_r   <= bready_nxt_s;
            done_r     <= done_nxt_s;
            busy_r     <= busy_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    // Base address may be reloaded at any time; a running job already holds its copy in awaddr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_r <= '0;
        end else if (NcNwc_initAddrEn) begin
            base_r <= NcNwc_initAddr;
        end else begin
            base_r <= base_r;
        end
    end

    // Result array capture, only when a job starts from IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r <= '0;
        end else if (capture_s) begin
            data_r <= FcNwc_result;
        end else begin
            data_r <= data_r;
        end
    end

    assign NwcFc_busy       = busy_r;
    assign NwcNc_done       = done_r;
    assign NwcNc_err        = err_r;
    assign NwcBus_awvalid   = awvalid_r;
    assign NwcBus_awaddr    = awaddr_r;
    assign NwcBus_awlen     = awlen_r;
    assign NwcBus_awuser_id = AWID;
    assign NwcBus_awuser_ap = 1'b1;
    assign NwcBus_wvalid    = wvalid_r;
    assign NwcBus_wdata     = wdata_r;
    assign NwcBus_wstrb     = {STRB_W{1'b1}};
    assign NwcBus_wlast     = wlast_r;
    assign NwcBus_bready    = bready_r;

endmodule

// File: tb/tb_fc_wr_burst_ctrl.sv
// Directed bench for fc_wr_burst_ctrl: a 10-word single-burst instance and a 40-word three-burst instance.
module tb_fc_wr_burst_ctrl;

    localparam int          WL    = 32;
    localparam int          AWD   = 28;
    localparam int          NA    = 10;
    localparam int          NBW   = 40;
    localparam logic [31:0] PAT_A = 32'hA500_0000;
    localparam logic [31:0] PAT_B = 32'hB700_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, en_a, en_b, aen_a, aen_b;
    logic [NA*WL-1:0]  res_a;
    logic [NBW*WL-1:0] res_b;
    logic [AWD-1:0]    init_addr;
    logic              awready, wready, bvalid;
    logic [1:0]        bresp;
    logic              sel;

    logic a_busy, a_done, a_awvalid, a_ap, a_wvalid, a_wlast, a_bready, a_err;
    logic b_busy, b_done, b_awvalid, b_ap, b_wvalid, b_wlast, b_bready, b_err;
    logic [AWD-1:0] a_awaddr, b_awaddr;
    logic [3:0]     a_awlen, b_awlen, a_id, b_id, a_wstrb, b_wstrb;
    logic [WL-1:0]  a_wdata, b_wdata;

    fc_wr_burst_ctrl #(.BATCH_SIZE(1), .BIAS_SIZE(10), .WORD_LEN(WL), .BURST_LEN(16), .ADDR_W(AWD)) dut_a (
        .clk(clk), .rst_n(rst_n), .FcNwc_result_en(en_a), .FcNwc_result(res_a), .NwcFc_busy(a_busy),
        .NcNwc_initAddr(init_addr), .NcNwc_initAddrEn(aen_a), .NwcNc_done(a_done),
        .NwcBus_awvalid(a_awvalid), .NwcBus_awaddr(a_awaddr), .NwcBus_awlen(a_awlen),
        .NwcBus_awuser_id(a_id), .NwcBus_awuser_ap(a_ap), .BusNwc_awready(awready),
        .NwcBus_wvalid(a_wvalid), .NwcBus_wdata(a_wdata), .NwcBus_wstrb(a_wstrb), .NwcBus_wlast(a_wlast),
        .BusNwc_wready(wready), .BusNwc_bvalid(bvalid), .BusNwc_bresp(bresp), .NwcBus_bready(a_bready),
        .NwcNc_err(a_err));

    fc_wr_burst_ctrl #(.BATCH_SIZE(2), .BIAS_SIZE(20), .WORD_LEN(WL), .BURST_LEN(16), .ADDR_W(AWD)) dut_b (
        .clk(clk), .rst_n(rst_n), .FcNwc_result_en(en_b), .FcNwc_result(res_b), .NwcFc_busy(b_busy),
        .NcNwc_initAddr(init_addr), .NcNwc_initAddrEn(aen_b), .NwcNc_done(b_done),
        .NwcBus_awvalid(b_awvalid), .NwcBus_awaddr(b_awaddr), .NwcBus_awlen(b_awlen),
        .NwcBus_awuser_id(b_id), .NwcBus_awuser_ap(b_ap), .BusNwc_awready(awready),
        .NwcBus_wvalid(b_wvalid), .NwcBus_wdata(b_wdata), .NwcBus_wstrb(b_wstrb), .NwcBus_wlast(b_wlast),
        .BusNwc_wready(wready), .BusNwc_bvalid(bvalid), .BusNwc_bresp(bresp), .NwcBus_bready(b_bready),
        .NwcNc_err(b_err));

    logic           m_busy, m_done, m_awvalid, m_ap, m_wvalid, m_wlast, m_bready, m_err;
    logic [AWD-1:0] m_awaddr;
    logic [3:0]     m_awlen, m_id, m_wstrb;
    logic [WL-1:0]  m_wdata;

    assign m_busy    = sel ? b_busy    : a_busy;
    assign m_done    = sel ? b_done    : a_done;
    assign m_awvalid = sel ? b_awvalid : a_awvalid;
    assign m_ap      = sel ? b_ap      : a_ap;
    assign m_wvalid  = sel ? b_wvalid  : a_wvalid;
    assign m_wlast   = sel ? b_wlast   : a_wlast;
    assign m_bready  = sel ? b_bready  : a_bready;
    assign m_err     = sel ? b_err     : a_err;
    assign m_awaddr  = sel ? b_awaddr  : a_awaddr;
    assign m_awlen   = sel ? b_awlen   : a_awlen;
    assign m_id      = sel ? b_id      : a_id;
    assign m_wstrb   = sel ? b_wstrb   : a_wstrb;
    assign m_wdata   = sel ? b_wdata   : a_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AWD-1:0] aw_addr_q[$];
    logic [3:0]     aw_len_q[$];
    logic [WL-1:0]  wd_q[$];
    int             wlast_idx_q[$];
    int             done_cyc, stall_bad, attr_bad, order_bad;
    bit             done_seen;
    logic           err_at_done, busy_mid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: all ready, 1: wready toggles, 2: awready low 5 cycles,
    // 3: re-trigger + base load during W and error on first response, 4: reset after 3 beats.
    task automatic run_job(input bit s, input int mode, input int budget);
        int   cyc, aw_wait, n_resp;
        bit   tog, injected, rst_pending, rst_done;
        logic prev_wv, prev_wr, prev_wl, prev_av, prev_ar;
        logic [WL-1:0]  prev_wd;
        logic [AWD-1:0] prev_aa;
        logic [3:0]     prev_al;
        sel = s;
        aw_addr_q.delete(); aw_len_q.delete(); wd_q.delete(); wlast_idx_q.delete();
        done_cyc = 0; done_seen = 1'b0; stall_bad = 0; attr_bad = 0; order_bad = 0;
        err_at_done = 1'b0; busy_mid = 1'b0;
        aw_wait = 0; n_resp = 0; tog = 1'b1; injected = 1'b0; rst_pending = 1'b0; rst_done = 1'b0;
        prev_wv = 1'b0; prev_wr = 1'b0; prev_wl = 1'b0; prev_av = 1'b0; prev_ar = 1'b0;
        prev_wd = '0; prev_aa = '0; prev_al = 4'd0;
        if (s) en_b = 1'b1; else en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0; en_b = 1'b0;
        cyc = 1;
        while (cyc <= budget && !done_seen) begin
            if (rst_pending) begin
                rst_n = 1'b1;
                rst_pending = 1'b0;
                chk("rst_awvalid", 64'(m_awvalid), 64'(0));
                chk("rst_wvalid", 64'(m_wvalid), 64'(0));
                chk("rst_bready", 64'(m_bready), 64'(0));
                chk("rst_done", 64'(m_done), 64'(0));
                chk("rst_busy", 64'(m_busy), 64'(0));
                chk("rst_awaddr", 64'(m_awaddr), 64'(0));
                chk("rst_awlen", 64'(m_awlen), 64'(0));
                chk("rst_wdata", 64'(m_wdata), 64'(0));
                chk("rst_wlast", 64'(m_wlast), 64'(0));
                chk("rst_wstrb", 64'(m_wstrb), 64'(4'hF));
            end
            awready = (mode == 2 && aw_wait < 5) ? 1'b0 : 1'b1;
            if (m_awvalid) aw_wait++;
            wready = (mode == 1) ? tog : 1'b1;
            tog = ~tog;
            bvalid = 1'b1;
            bresp = (mode == 3 && n_resp == 0) ? 2'b10 : 2'b00;
            if (prev_wv && !prev_wr && (!m_wvalid || m_wdata !== prev_wd || m_wlast !== prev_wl)) stall_bad++;
            if (prev_av && !prev_ar && (!m_awvalid || m_awaddr !== prev_aa || m_awlen !== prev_al)) stall_bad++;
            if (m_wvalid && aw_addr_q.size() == 0) order_bad++;
            if (m_awvalid && awready) begin
                aw_addr_q.push_back(m_awaddr);
                aw_len_q.push_back(m_awlen);
                if (m_ap !== 1'b1 || m_id !== 4'b0110) attr_bad++;
            end
            if (m_wvalid && wready) begin
                if (m_wlast) wlast_idx_q.push_back(wd_q.size());
                wd_q.push_back(m_wdata);
                if (wd_q.size() == 1) busy_mid = m_busy;
            end
            if (m_bready && bvalid) n_resp++;
            if (m_done) begin
                done_seen = 1'b1;
                done_cyc = cyc;
                err_at_done = m_err;
            end
            if (mode == 3 && m_wvalid && !injected) begin
                injected = 1'b1;
                res_b = ~res_b;
                en_b = 1'b1;
                aen_b = 1'b1;
                init_addr = 28'h200;
            end else begin
                en_b = 1'b0;
                aen_b = 1'b0;
            end
            if (mode == 4 && wd_q.size() == 3 && !rst_done) begin
                rst_n = 1'b0;
                rst_pending = 1'b1;
                rst_done = 1'b1;
            end
            prev_wv = m_wvalid; prev_wr = wready; prev_wd = m_wdata; prev_wl = m_wlast;
            prev_av = m_awvalid; prev_ar = awready; prev_aa = m_awaddr; prev_al = m_awlen;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_job(input int n, input logic [AWD-1:0] base, input logic [31:0] pat,
                             input bit inv, input int exp_done, input bit exp_err);
        int nb;
        logic [31:0] e;
        nb = (n + 15) / 16;
        chk("done_seen", 64'(done_seen), 64'(1));
        chk("done_cyc", 64'(done_cyc), 64'(exp_done));
        chk("aw_count", 64'(aw_addr_q.size()), 64'(nb));
        for (int k = 0; k < nb; k++) begin
            if (k < aw_addr_q.size()) begin
                chk($sformatf("awaddr%0d", k), 64'(aw_addr_q[k]), 64'(base + AWD'(k * 64)));
                chk($sformatf("awlen%0d", k), 64'(aw_len_q[k]), 64'((k < nb - 1) ? 15 : n - (nb - 1) * 16 - 1));
            end
        end
        chk("beat_count", 64'(wd_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wd_q.size()) begin
                e = pat + 32'(i);
                if (inv) e = ~e;
                chk($sformatf("wdata%0d", i), 64'(wd_q[i]), 64'(e));
            end
        end
        chk("wlast_count", 64'(wlast_idx_q.size()), 64'(nb));
        for (int k = 0; k < nb; k++) begin
            if (k < wlast_idx_q.size())
                chk($sformatf("wlast_at%0d", k), 64'(wlast_idx_q[k]), 64'((((k + 1) * 16 < n) ? (k + 1) * 16 : n) - 1));
        end
        chk("stall_hold", 64'(stall_bad), 64'(0));
        chk("aw_attr", 64'(attr_bad), 64'(0));
        chk("w_before_aw", 64'(order_bad), 64'(0));
        chk("err", 64'(err_at_done), 64'(exp_err));
        chk("busy_mid", 64'(busy_mid), 64'(1));
        chk("busy_idle", 64'(m_busy), 64'(0));
    endtask

    initial begin
        sel = 1'b0;
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; aen_a = 1'b0; aen_b = 1'b0;
        init_addr = '0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        for (int i = 0; i < NA; i++) res_a[i*WL +: WL] = PAT_A + 32'(i);
        for (int i = 0; i < NBW; i++) res_b[i*WL +: WL] = PAT_B + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(a_busy), 64'(0));
        chk("reset_awvalid", 64'(a_awvalid), 64'(0));
        chk("reset_wstrb", 64'(a_wstrb), 64'(4'hF));
        chk("reset_err", 64'(a_err), 64'(0));
        chk("reset_awaddr", 64'(a_awaddr), 64'(0));
        chk("reset_b_wvalid", 64'(b_wvalid), 64'(0));
        chk("reset_b_bready", 64'(b_bready), 64'(0));
        chk("reset_b_done", 64'(b_done), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        init_addr = 28'h100; aen_a = 1'b1;
        @(posedge clk); #1;
        aen_a = 1'b0;

        run_job(1'b0, 0, 40);  check_job(NA, 28'h100, PAT_A, 1'b0, 13, 1'b0);
        run_job(1'b1, 0, 80);  check_job(NBW, 28'h0, PAT_B, 1'b0, 47, 1'b0);
        run_job(1'b0, 1, 60);  check_job(NA, 28'h100, PAT_A, 1'b0, 23, 1'b0);
        run_job(1'b0, 2, 60);  check_job(NA, 28'h100, PAT_A, 1'b0, 18, 1'b0);
        run_job(1'b1, 3, 80);  check_job(NBW, 28'h0, PAT_B, 1'b0, 47, 1'b1);
        run_job(1'b1, 0, 80);  check_job(NBW, 28'h200, PAT_B, 1'b1, 47, 1'b0);
        run_job(1'b0, 4, 30);
        chk("no_done_after_reset", 64'(done_seen), 64'(0));
        run_job(1'b0, 0, 40);  check_job(NA, 28'h0, PAT_A, 1'b0, 13, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
